// File: rtl/servo_pkg.sv
// Constants and FSM state type shared by the servo PWM generator and decoder.
package servo_pkg;

    localparam int unsigned CLK_HZ      = 27_000_000;
    localparam int unsigned PWM_PERIOD  = 500_001;
    localparam int unsigned MIN_W       = 16_000;
    localparam int unsigned MAX_W       = 66_000;
    localparam int unsigned MID_W       = 38_000;
    localparam int unsigned DEF_TIMEOUT = 1_000_000;
    localparam int unsigned DEF_FILT    = 4;

    localparam int unsigned W_BITS = 20;
    localparam int unsigned P_BITS = 21;

    typedef enum logic [1:0] {
        SYNC,
        WAIT_RISE,
        HIGH,
        LOW
    } servo_state_e;

endpackage

// File: rtl/servo_pwm_decoder_if.sv
// Measurement result bundle from the PWM decoder to its consumer.
interface servo_pwm_decoder_if;
    import servo_pkg::*;

    logic [W_BITS-1:0] width;
    logic [P_BITS-1:0] period;
    logic              valid;
    logic              in_range;
    logic              timeout;
    logic              active;

    modport master (
        output width, period, valid, in_range, timeout, active
    );

    modport slave (
        input width, period, valid, in_range, timeout, active
    );

endinterface

// File: rtl/pwm_in_filter.sv
// Two-flop synchronizer plus glitch filter; a level change is accepted only after
// FILT consecutive synchronized samples at the new level.
module pwm_in_filter #(
    parameter int unsigned FILT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic pf,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = $clog2(FILT + 1);

    logic          s1_q, s2_q;
    logic          pf_q, pf_prev_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            pf_q      <= 1'b0;
            pf_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= pwm_in;
            s2_q      <= s1_q;
            pf_prev_q <= pf_q;
            if (s2_q == pf_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILT - 1)) begin
                // FILT-th consecutive differing sample: accept the new level
                pf_q  <= s2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign pf   = pf_q;
    assign rise = pf_q & ~pf_prev_q;
    assign fall = ~pf_q & pf_prev_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Measures high time and rising-to-rising period of a servo PWM input in clock cycles,
// with range check and loss-of-signal detection.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int unsigned MIN_W   = servo_pkg::MIN_W,
    parameter int unsigned MAX_W   = servo_pkg::MAX_W,
    parameter int unsigned TIMEOUT = servo_pkg::DEF_TIMEOUT,
    parameter int unsigned FILT    = servo_pkg::DEF_FILT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pwm_in,
    servo_pwm_decoder_if.master        meas
);

    localparam logic [W_BITS-1:0] MIN_L      = W_BITS'(MIN_W);
    localparam logic [W_BITS-1:0] MAX_L      = W_BITS'(MAX_W);
    localparam logic [P_BITS-1:0] TO_LIM     = P_BITS'(TIMEOUT);
    // Low time required in SYNC; longer than the filter latency so a line that is
    // already high at reset release is seen as high before we arm.
    localparam logic [P_BITS-1:0] SETTLE_LIM = P_BITS'(FILT + 3);

    logic pf, rise, fall;

    pwm_in_filter #(
        .FILT (FILT)
    ) u_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .pf     (pf),
        .rise   (rise),
        .fall   (fall)
    );

    servo_state_e      state_q, state_d;
    logic [W_BITS-1:0] hi_cnt_q, hi_cnt_d, hi_lat_q, hi_lat_d;
    logic [P_BITS-1:0] per_cnt_q, per_cnt_d, idle_q, idle_d;
    logic [W_BITS-1:0] width_q, width_d;
    logic [P_BITS-1:0] period_q, period_d;
    logic              valid_q, valid_d;
    logic              in_range_q, in_range_d;
    logic              timeout_q, timeout_d;
    logic              active_q, active_d;

    logic [W_BITS-1:0] hi_inc;
    logic [P_BITS-1:0] per_inc, idle_inc;

    // Saturating increments
    assign hi_inc   = (&hi_cnt_q)  ? hi_cnt_q  : hi_cnt_q  + W_BITS'(1);
    assign per_inc  = (&per_cnt_q) ? per_cnt_q : per_cnt_q + P_BITS'(1);
    assign idle_inc = (&idle_q)    ? idle_q    : idle_q    + P_BITS'(1);

    always_comb begin
        state_d    = state_q;
        hi_cnt_d   = hi_cnt_q;
        hi_lat_d   = hi_lat_q;
        per_cnt_d  = per_cnt_q;
        idle_d     = idle_q;
        width_d    = width_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        in_range_d = in_range_q;
        timeout_d  = timeout_q;
        active_d   = active_q;

        case (state_q)
            SYNC: begin
                if (pf) begin
                    idle_d = '0;
                end else if (idle_q >= SETTLE_LIM) begin
                    idle_d  = '0;
                    state_d = WAIT_RISE;
                end else begin
                    idle_d = idle_inc;
                end
            end
            WAIT_RISE: begin
                if (rise) begin
                    hi_cnt_d  = W_BITS'(1);
                    per_cnt_d = P_BITS'(1);
                    idle_d    = '0;
                    state_d   = HIGH;
                end else begin
                    idle_d = idle_inc;
                    if (idle_q >= TO_LIM) begin
                        timeout_d = 1'b1;
                        active_d  = 1'b0;
                    end
                end
            end
            HIGH: begin
                if (fall) begin
                    hi_lat_d  = hi_cnt_q;
                    per_cnt_d = per_inc;
                    state_d   = LOW;
                end else if (per_cnt_q >= TO_LIM) begin
                    // Stuck high: resynchronise on the next low level
                    timeout_d = 1'b1;
                    active_d  = 1'b0;
                    idle_d    = '0;
                    state_d   = SYNC;
                end else begin
                    hi_cnt_d  = hi_inc;
                    per_cnt_d = per_inc;
                end
            end
            LOW: begin
                if (rise) begin
                    width_d    = hi_lat_q;
                    period_d   = per_cnt_q;
                    in_range_d = (hi_lat_q >= MIN_L) && (hi_lat_q <= MAX_L);
                    valid_d    = 1'b1;
                    timeout_d  = 1'b0;
                    active_d   = 1'b1;
                    hi_cnt_d   = W_BITS'(1);
                    per_cnt_d  = P_BITS'(1);
                    state_d    = HIGH;
                end else if (per_cnt_q >= TO_LIM) begin
                    timeout_d = 1'b1;
                    active_d  = 1'b0;
                    idle_d    = '0;
                    state_d   = WAIT_RISE;
                end else begin
                    per_cnt_d = per_inc;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SYNC;
            hi_cnt_q   <= '0;
            hi_lat_q   <= '0;
            per_cnt_q  <= '0;
            idle_q     <= '0;
            width_q    <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            in_range_q <= 1'b0;
            timeout_q  <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_cnt_q   <= hi_cnt_d;
            hi_lat_q   <= hi_lat_d;
            per_cnt_q  <= per_cnt_d;
            idle_q     <= idle_d;
            width_q    <= width_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            in_range_q <= in_range_d;
            timeout_q  <= timeout_d;
            active_q   <= active_d;
        end
    end

    assign meas.width    = width_q;
    assign meas.period   = period_q;
    assign meas.valid    = valid_q;
    assign meas.in_range = in_range_q;
    assign meas.timeout  = timeout_q;
    assign meas.active   = active_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder with scaled-down timing parameters.
module tb_servo_pwm_decoder;

    localparam int unsigned T_MIN  = 160;
    localparam int unsigned T_MAX  = 660;
    localparam int unsigned T_TO   = 3000;
    localparam int unsigned T_FILT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pwm_in = 1'b0;

    servo_pwm_decoder_if m ();

    servo_pwm_decoder #(
        .MIN_W   (T_MIN),
        .MAX_W   (T_MAX),
        .TIMEOUT (T_TO),
        .FILT    (T_FILT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .meas   (m)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every valid pulse and the first cycle of each timeout assertion
    int   vcount = 0;
    int   valid_cyc = 0;
    int   to_cyc = 0;
    int   pulse_err = 0;
    int   cap_w = 0, cap_p = 0;
    logic cap_r = 1'b0, cap_a = 1'b0, cap_t = 1'b0;
    logic v_prev = 1'b0, to_prev = 1'b0;

    always @(negedge clk) begin
        if (m.valid) begin
            vcount++;
            cap_w = int'(m.width);
            cap_p = int'(m.period);
            cap_r = m.in_range;
            cap_a = m.active;
            cap_t = m.timeout;
            valid_cyc = cyc;
            if (v_prev) pulse_err++;
        end
        if (m.timeout && !to_prev) to_cyc = cyc;
        v_prev  = m.valid;
        to_prev = m.timeout;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One period: high for hi cycles, then low; optionally invert g_len cycles at g_at
    task automatic send(input int hi, input int per, input int g_at, input int g_len);
        for (int c = 0; c < per; c++) begin
            logic lvl;
            lvl = (c < hi);
            if (g_len > 0 && c >= g_at && c < g_at + g_len) lvl = ~lvl;
            pwm_in = lvl;
            tick(1);
        end
    endtask

    typedef struct {
        int   hi;
        int   per;
        int   exp_w;
        int   exp_p;
        logic exp_r;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int base, start;

        vecs[0] = '{380, 2001, 380, 2001, 1'b1};
        vecs[1] = '{380, 2001, 380, 2001, 1'b1};
        vecs[2] = '{100, 2001, 100, 2001, 1'b0};
        vecs[3] = '{700, 1500, 700, 1500, 1'b0};
        vecs[4] = '{160, 1800, 160, 1800, 1'b1};
        vecs[5] = '{660, 2001, 660, 2001, 1'b1};
        vecs[6] = '{159, 2001, 159, 2001, 1'b0};
        vecs[7] = '{661, 1600, 661, 1600, 1'b0};
        vecs[8] = '{380, 2001, 380, 2001, 1'b1};

        tick(3);
        chk("rst_width", m.width, 0);
        chk("rst_period", m.period, 0);
        chk("rst_valid", m.valid, 0);
        chk("rst_in_range", m.in_range, 0);
        chk("rst_timeout", m.timeout, 0);
        chk("rst_active", m.active, 0);
        rst_n = 1'b1;
        tick(20);

        // Table: the rise of vector i reports the measurement of vector i-1
        base = vcount;
        for (int i = 0; i < 9; i++) begin
            start = cyc;
            send(vecs[i].hi, vecs[i].per, 0, 0);
            if (i == 0) begin
                chk("first_rise_no_valid", vcount, base);
            end else begin
                chk($sformatf("vec%0d_count", i), vcount, base + i);
                chk($sformatf("vec%0d_width", i), cap_w, vecs[i-1].exp_w);
                chk($sformatf("vec%0d_period", i), cap_p, vecs[i-1].exp_p);
                chk($sformatf("vec%0d_in_range", i), cap_r, vecs[i-1].exp_r);
                chk($sformatf("vec%0d_active", i), cap_a, 1);
                chk($sformatf("vec%0d_latency", i), valid_cyc - start, 3 + T_FILT);
            end
        end

        // Line held low after the last rise
        tick(3200);
        chk("lost_timeout", m.timeout, 1);
        chk("lost_active", m.active, 0);
        chk("lost_exact_cycles", to_cyc - valid_cyc, T_TO);
        chk("lost_width_hold", m.width, 661);
        chk("lost_period_hold", m.period, 1600);

        // Resume: first rise only arms, second clears timeout
        base = vcount;
        send(380, 2001, 0, 0);
        chk("resume1_no_valid", vcount, base);
        chk("resume1_timeout", m.timeout, 1);
        send(420, 2001, 0, 0);
        chk("resume2_count", vcount, base + 1);
        chk("resume2_timeout_at_valid", cap_t, 0);
        chk("resume2_width", cap_w, 380);
        chk("resume2_period", cap_p, 2001);

        // 2-cycle high glitch in LOW, then 3-cycle dropout in HIGH
        send(380, 2001, 1000, 2);
        chk("g1_count", vcount, base + 2);
        chk("g1_width", cap_w, 420);
        send(380, 2001, 150, 3);
        chk("g2_count", vcount, base + 3);
        chk("g2_width", cap_w, 380);
        chk("g2_period", cap_p, 2001);
        send(380, 2001, 0, 0);
        chk("g3_count", vcount, base + 4);
        chk("g3_width", cap_w, 380);
        chk("g3_period", cap_p, 2001);

        // Stuck high
        pwm_in = 1'b1;
        tick(3300);
        chk("stuck_timeout", m.timeout, 1);
        chk("stuck_active", m.active, 0);
        chk("stuck_width_hold", m.width, 380);
        chk("stuck_period_hold", m.period, 2001);
        pwm_in = 1'b0;
        tick(300);
        base = vcount;
        send(380, 2001, 0, 0);
        chk("stuck_rel1_no_valid", vcount, base);
        send(300, 1700, 0, 0);
        chk("stuck_rel2_count", vcount, base + 1);
        chk("stuck_rel2_width", cap_w, 380);
        chk("stuck_rel2_period", cap_p, 2001);
        chk("stuck_rel2_timeout", m.timeout, 0);
        send(380, 2001, 0, 0);
        chk("stuck_rel3_width", cap_w, 300);
        chk("stuck_rel3_period", cap_p, 1700);

        // Asynchronous reset mid-HIGH, partial pulse at release
        pwm_in = 1'b1;
        tick(100);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_width", m.width, 0);
        chk("midrst_period", m.period, 0);
        chk("midrst_valid", m.valid, 0);
        chk("midrst_in_range", m.in_range, 0);
        chk("midrst_timeout", m.timeout, 0);
        chk("midrst_active", m.active, 0);
        tick(4);
        rst_n = 1'b1;
        tick(200);
        pwm_in = 1'b0;
        tick(1500);
        base = vcount;
        send(380, 2001, 0, 0);
        chk("postrst_full1_no_valid", vcount, base);
        send(380, 2001, 0, 0);
        chk("postrst_full2_count", vcount, base + 1);
        chk("postrst_full2_width", cap_w, 380);
        chk("postrst_full2_period", cap_p, 2001);

        chk("valid_single_cycle", pulse_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
